vga_scan_timing: RTL and testbench

- Produces the raster scan for the Pong display: 800x600 @ 72 Hz timing with a 50 MHz pixel rate.
- Drives the current pixel coordinate (x, y) to the combinational pixel generators (walls, net, paddles, ball), which return a summed 12-bit rgb.
- Registers that rgb together with sync and blanking, and drives the VGA connector pins.
- Advances one pixel per pix_en strobe on a single system clock.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/scan_counter.sv | 44 ++++
 rtl/vga_scan_timing.sv | 120 ++++++++++++
 tb/tb_vga_scan_timing.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 800x600@72 raster constants and pixel types for the scan timing
// block and the Pong pixel generators.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 56;
  localparam int VGA_H_SYNC   = 120;
  localparam int VGA_H_BP     = 64;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 37;
  localparam int VGA_V_SYNC   = 6;
  localparam int VGA_V_BP     = 23;
  localparam logic VGA_H_POL  = 1'b1;
  localparam logic VGA_V_POL  = 1'b1;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [10:0] coord_t;
  typedef logic [11:0] rgb_t;

  // True when c lies in the half-open window [lo, lo+len).
  function automatic logic in_window(input coord_t c, input int lo, input int len);
    return (c >= coord_t'(lo)) && (c < coord_t'(lo + len));
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Modulo-TOTAL raster counter; wrap flags the enabled step from TOTAL-1 to 0
// so that a horizontal instance can clock a vertical one.
module scan_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = VGA_H_TOTAL
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t cnt,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  coord_t cnt_q;
  coord_t cnt_d;

  // Next-count and wrap decode.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = en && (cnt_q == LAST);
    if (!en) begin
      cnt_d = cnt_q;
    end else if (cnt_q == LAST) begin
      cnt_d = 11'd0;
    end else begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 11'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_scan_timing.sv
// Raster scan generator: pixel coordinates for the pixel generators and a
// one-pixel registered output stage for colour, sync and frame tick.
module vga_scan_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic H_POL    = VGA_H_POL,
  parameter logic V_POL    = VGA_V_POL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [11:0] rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        active,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  coord_t hcnt_s;
  coord_t vcnt_s;
  logic   h_wrap_s;
  logic   v_wrap_s;
  logic   active_s;
  logic   hs_raw_s;
  logic   vs_raw_s;

  rgb_t vga_rgb_q;
  rgb_t vga_rgb_d;
  logic hsync_q;
  logic hsync_d;
  logic vsync_q;
  logic vsync_d;
  logic frame_tick_q;
  logic frame_tick_d;
  // Counters currently sit at (0,0): true out of reset and after a frame wrap.
  logic origin_q;
  logic origin_d;

  scan_counter #(.TOTAL(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .cnt   (hcnt_s),
    .wrap  (h_wrap_s)
  );

  scan_counter #(.TOTAL(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_wrap_s),
    .cnt   (vcnt_s),
    .wrap  (v_wrap_s)
  );

  assign active_s = (hcnt_s < coord_t'(H_ACTIVE)) && (vcnt_s < coord_t'(V_ACTIVE));
  assign hs_raw_s = in_window(hcnt_s, H_ACTIVE + H_FP, H_SYNC);
  assign vs_raw_s = in_window(vcnt_s, V_ACTIVE + V_FP, V_SYNC);

  // Output-stage next state; everything but the tick holds while stalled.
  always_comb begin
    vga_rgb_d    = vga_rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    origin_d     = origin_q;
    frame_tick_d = 1'b0;
    if (pix_en) begin
      vga_rgb_d    = active_s ? rgb_in : 12'h000;
      hsync_d      = hs_raw_s ? H_POL : ~H_POL;
      vsync_d      = vs_raw_s ? V_POL : ~V_POL;
      frame_tick_d = origin_q;
      origin_d     = v_wrap_s;
    end else begin
      vga_rgb_d    = vga_rgb_q;
      hsync_d      = hsync_q;
      vsync_d      = vsync_q;
      origin_d     = origin_q;
      frame_tick_d = 1'b0;
    end
  end

  // Output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb_q    <= 12'h000;
      hsync_q      <= ~H_POL;
      vsync_q      <= ~V_POL;
      frame_tick_q <= 1'b0;
      origin_q     <= 1'b1;
    end else begin
      vga_rgb_q    <= vga_rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
      origin_q     <= origin_d;
    end
  end

  assign x          = hcnt_s;
  assign y          = vcnt_s;
  assign active     = active_s;
  assign frame_tick = frame_tick_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vga_rgb    = vga_rgb_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a full-size instance for line-level timing and a
// shrunken-timing instance for frame-level behaviour, both against one model.
module tb_vga_scan_timing;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [11:0] rgb_in = 12'h000;

  logic [10:0] ax[2];
  logic [10:0] ay[2];
  logic        aact[2];
  logic        aft[2];
  logic        ahs[2];
  logic        avs[2];
  logic [11:0] argb[2];

  // Timing per instance: index 0 = real 800x600, index 1 = small.
  int ha[2]  = '{800, 8};
  int hfp[2] = '{56, 2};
  int hsw[2] = '{120, 3};
  int hbp[2] = '{64, 2};
  int va[2]  = '{600, 5};
  int vfp[2] = '{37, 1};
  int vsw[2] = '{6, 2};
  int vbp[2] = '{23, 1};

  int n_chk = 0;
  int n_pass = 0;

  // Model: n = pixels advanced since reset; expected output registers.
  int          n[2];
  logic [11:0] e_rgb[2];
  logic        e_hs[2];
  logic        e_vs[2];
  logic        e_ft[2];

  always #5 clk = ~clk;

  vga_scan_timing u_dut_full (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rgb_in(rgb_in),
    .x(ax[0]), .y(ay[0]), .active(aact[0]), .frame_tick(aft[0]),
    .hsync(ahs[0]), .vsync(avs[0]), .vga_rgb(argb[0])
  );

  vga_scan_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rgb_in(rgb_in),
    .x(ax[1]), .y(ay[1]), .active(aact[1]), .frame_tick(aft[1]),
    .hsync(ahs[1]), .vsync(avs[1]), .vga_rgb(argb[1])
  );

  function automatic int htot(int k);
    return ha[k] + hfp[k] + hsw[k] + hbp[k];
  endfunction
  function automatic int vtot(int k);
    return va[k] + vfp[k] + vsw[k] + vbp[k];
  endfunction
  function automatic int mx(int k);
    return n[k] % htot(k);
  endfunction
  function automatic int my(int k);
    return (n[k] / htot(k)) % vtot(k);
  endfunction
  function automatic logic m_active(int k);
    return (mx(k) < ha[k]) && (my(k) < va[k]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; e_rgb[k] = 12'h000; e_hs[k] = 1'b0; e_vs[k] = 1'b0; e_ft[k] = 1'b0;
    end
  endtask

  // What the coming clock edge should do, from the raster rules.
  task automatic model_edge();
    int px, py;
    for (int k = 0; k < 2; k++) begin
      px = mx(k);
      py = my(k);
      if (!rst_n) begin
        n[k] = 0; e_rgb[k] = 12'h000; e_hs[k] = 1'b0; e_vs[k] = 1'b0; e_ft[k] = 1'b0;
      end else if (pix_en) begin
        e_rgb[k] = m_active(k) ? rgb_in : 12'h000;
        e_hs[k]  = (px >= ha[k] + hfp[k]) && (px < ha[k] + hfp[k] + hsw[k]);
        e_vs[k]  = (py >= va[k] + vfp[k]) && (py < va[k] + vfp[k] + vsw[k]);
        e_ft[k]  = (px == 0) && (py == 0);
        n[k]     = n[k] + 1;
      end else begin
        e_ft[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("x[%0d]", k), int'(ax[k]), mx(k));
      chk($sformatf("y[%0d]", k), int'(ay[k]), my(k));
      chk($sformatf("active[%0d]", k), int'(aact[k]), int'(m_active(k)));
      chk($sformatf("hsync[%0d]", k), int'(ahs[k]), int'(e_hs[k]));
      chk($sformatf("vsync[%0d]", k), int'(avs[k]), int'(e_vs[k]));
      chk($sformatf("vga_rgb[%0d]", k), int'(argb[k]), int'(e_rgb[k]));
      chk($sformatf("frame_tick[%0d]", k), int'(aft[k]), int'(e_ft[k]));
    end
  endtask

  // Drive inputs (at the falling edge), clock once, check at the next falling edge.
  task automatic step(input logic pen, input logic [11:0] rgb);
    pix_en = pen;
    rgb_in = rgb;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b1, 12'hABC);
    step(1'b1, 12'h123);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        pen;
    logic [11:0] rgb;
    int          ex;
    logic [11:0] ergb;
    logic        eft;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int hs_cnt, first_hs_x, saw_wrap, prev_x, prev_y, prev_vs;
    int vs_cnt, ft_cnt, saw_vwrap, pre_y, t_first, t_second, found;

    tbl[0] = '{pen: 1'b1, rgb: 12'h123, ex: 1, ergb: 12'h123, eft: 1'b1};
    tbl[1] = '{pen: 1'b0, rgb: 12'h456, ex: 1, ergb: 12'h123, eft: 1'b0};
    tbl[2] = '{pen: 1'b0, rgb: 12'h789, ex: 1, ergb: 12'h123, eft: 1'b0};
    tbl[3] = '{pen: 1'b1, rgb: 12'hABC, ex: 2, ergb: 12'hABC, eft: 1'b0};
    tbl[4] = '{pen: 1'b1, rgb: 12'hFFF, ex: 3, ergb: 12'hFFF, eft: 1'b0};
    tbl[5] = '{pen: 1'b0, rgb: 12'h000, ex: 3, ergb: 12'hFFF, eft: 1'b0};

    @(negedge clk);
    do_reset();

    // Post-reset vectors including a 1,0,0,1 stall.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].pen, tbl[i].rgb);
      chk($sformatf("tbl%0d_x", i), int'(ax[0]), tbl[i].ex);
      chk($sformatf("tbl%0d_rgb", i), int'(argb[0]), int'(tbl[i].ergb));
      chk($sformatf("tbl%0d_ft", i), int'(aft[0]), int'(tbl[i].eft));
      chk($sformatf("tbl%0d_hs", i), int'(ahs[0]), 0);
    end

    // One full line on the real timing with white input.
    do_reset();
    hs_cnt = 0; first_hs_x = -1; saw_wrap = 0;
    prev_x = int'(ax[0]);
    for (int i = 0; i < 1045; i++) begin
      step(1'b1, 12'hFFF);
      if (ahs[0]) begin
        hs_cnt++;
        if (first_hs_x < 0) first_hs_x = int'(ax[0]);
      end
      if (ax[0] == 11'd800) chk("last_visible_rgb", int'(argb[0]), 12'hFFF);
      if (ax[0] == 11'd801) chk("first_blank_rgb", int'(argb[0]), 12'h000);
      if (prev_x == 1039 && ax[0] == 11'd0) begin
        saw_wrap = 1;
        chk("line_wrap_y", int'(ay[0]), 1);
      end
      prev_x = int'(ax[0]);
    end
    chk("hsync_width", hs_cnt, 120);
    chk("hsync_start_x", first_hs_x, 857);
    chk("line_wrap_seen", saw_wrap, 1);

    // One small frame: vsync width, single tick, vertical blanking, y wrap.
    do_reset();
    vs_cnt = 0; ft_cnt = 0; saw_vwrap = 0; prev_vs = 0; prev_y = 0;
    for (int i = 0; i < 135; i++) begin
      pre_y = my(1);
      step(1'b1, 12'hFFF);
      if (avs[1]) vs_cnt++;
      if (aft[1]) ft_cnt++;
      if (pre_y == 5) chk("vblank_rgb", int'(argb[1]), 12'h000);
      if (avs[1] && prev_vs == 0) chk("vsync_rise_at_line_start", int'(ax[1]), 1);
      if (prev_y == 8 && ay[1] == 11'd0) saw_vwrap = 1;
      prev_vs = int'(avs[1]);
      prev_y = int'(ay[1]);
    end
    chk("vsync_width", vs_cnt, 30);
    chk("frame_tick_count", ft_cnt, 1);
    chk("frame_wrap_seen", saw_vwrap, 1);

    // Randomized pixel strobe and colour against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 12'($urandom_range(0, 4095)));
    end

    // Mid-frame reset with both syncs active on the small instance.
    found = 0;
    for (int i = 0; i < 500 && found == 0; i++) begin
      if (mx(1) == 11 && my(1) == 6) found = 1;
      else step(1'b1, 12'($urandom_range(0, 4095)));
    end
    chk("midframe_reach", found, 1);
    chk("midframe_hs_before", int'(ahs[1]), 1);
    chk("midframe_vs_before", int'(avs[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("midframe_x", int'(ax[1]), 0);
    chk("midframe_y", int'(ay[1]), 0);
    chk("midframe_hs", int'(ahs[1]), 0);
    chk("midframe_vs", int'(avs[1]), 0);
    model_reset();
    step(1'b1, 12'h000);
    rst_n = 1'b1;
    t_first = -1; t_second = -1;
    for (int i = 1; i <= 400 && t_second < 0; i++) begin
      step(1'b1, 12'($urandom_range(0, 4095)));
      if (aft[1]) begin
        if (t_first < 0) t_first = i;
        else t_second = i;
      end
    end
    chk("post_reset_first_tick", t_first, 1);
    chk("post_reset_frame_len", t_second - t_first, 135);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
